// File: rtl/fetch2_if.sv
// fetch2 -> decode instruction-queue head handshake.
// master drives the head fields, slave accepts with out_ready.
interface fetch2_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [31:0] out_btb_pre;
   logic        out_excp_valid;
   logic [14:0] out_excp_code;
   logic [31:0] out_excp_badv;

   modport master (
      output out_valid, out_pc, out_inst, out_btb_pre,
      output out_excp_valid, out_excp_code, out_excp_badv,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_pc, out_inst, out_btb_pre,
      input  out_excp_valid, out_excp_code, out_excp_badv,
      output out_ready
   );
endinterface

// File: rtl/fetch2.sv
// Second fetch stage: joins the fetch1 packet with the icache word
// and queues {pc, inst, btb_pre, excp} for decode.
module fetch2 #(
   parameter int          IQ_DEPTH = 4,
   parameter logic [31:0] NOP_INST = 32'h03400000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_is_flush,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_btb_pre,
   input  logic        in_excp_valid,
   input  logic [14:0] in_excp_code,
   input  logic [31:0] in_excp_badv,
   input  logic        icache_ready,
   input  logic [31:0] icache_inst,
   input  logic        is_flush,
   output logic        stall_req,
   output logic [$clog2(IQ_DEPTH):0] iq_count,
   fetch2_if.master    iq
);
   localparam int PW = $clog2(IQ_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] btb_pre;
      logic        excp_valid;
      logic [14:0] excp_code;
      logic [31:0] excp_badv;
   } iq_ent_t;

   typedef enum logic [1:0] {
      EMPTY,
      WAIT_IC,
      HAVE_INST
   } s2_st_t;

   s2_st_t      st;
   logic [31:0] s2_pc;
   logic [31:0] s2_btb_pre;
   logic        s2_ev;
   logic [14:0] s2_ec;
   logic [31:0] s2_eb;
   logic [31:0] inst_buf;

   iq_ent_t     mem [IQ_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   logic    s2_valid;
   logic    have_inst;
   logic    full;
   logic    push;
   logic    pop;
   iq_ent_t new_ent;
   iq_ent_t head;

   always_comb begin
      s2_valid  = (st != EMPTY);
      have_inst = s2_ev | (st == HAVE_INST) | icache_ready;
      full      = (iq_count == CW'(IQ_DEPTH));
      push      = s2_valid & have_inst & ~full & ~is_flush;
      stall_req = s2_valid & ~push & ~is_flush;
      pop       = iq.out_valid & iq.out_ready;
   end

   always_comb begin
      new_ent            = '0;
      new_ent.pc         = s2_pc;
      new_ent.btb_pre    = s2_btb_pre;
      new_ent.excp_valid = s2_ev;
      new_ent.excp_code  = s2_ec;
      new_ent.excp_badv  = s2_eb;
      unique case (1'b1)
         s2_ev:             new_ent.inst = NOP_INST;
         (st == HAVE_INST): new_ent.inst = inst_buf;
         default:           new_ent.inst = icache_inst;
      endcase
   end

   // Stalled non-excepting packet keeps the icache word so it need not repeat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= EMPTY;
         s2_pc      <= '0;
         s2_btb_pre <= '0;
         s2_ev      <= 1'b0;
         s2_ec      <= '0;
         s2_eb      <= '0;
         inst_buf   <= '0;
      end else if (is_flush) begin
         st <= EMPTY;
      end else if (!stall_req) begin
         st         <= in_is_flush ? EMPTY : WAIT_IC;
         s2_pc      <= in_pc;
         s2_btb_pre <= in_btb_pre;
         s2_ev      <= in_excp_valid;
         s2_ec      <= in_excp_code;
         s2_eb      <= in_excp_badv;
      end else if (icache_ready && !s2_ev) begin
         inst_buf <= icache_inst;
         st       <= HAVE_INST;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         iq_count <= '0;
         for (int i = 0; i < IQ_DEPTH; i++)
            mem[i] <= '0;
      end else if (is_flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         iq_count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= new_ent;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            iq_count <= iq_count + CW'(1);
         else if (pop && !push)
            iq_count <= iq_count - CW'(1);
      end
   end

   assign head              = mem[rd_ptr];
   assign iq.out_valid      = (iq_count != '0) & ~is_flush;
   assign iq.out_pc         = head.pc;
   assign iq.out_inst       = head.inst;
   assign iq.out_btb_pre    = head.btb_pre;
   assign iq.out_excp_valid = head.excp_valid;
   assign iq.out_excp_code  = head.excp_code;
   assign iq.out_excp_badv  = head.excp_badv;
endmodule

// File: tb/tb_fetch2.sv
// fetch2 bench: fetch1/icache/decode models feed a packet
// scoreboard; a monitor checks every queue head popped.
module tb_fetch2;
   localparam int          D   = 4;
   localparam logic [31:0] NOP = 32'h03400000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_is_flush;
   logic [31:0] in_pc;
   logic [31:0] in_btb_pre;
   logic        in_excp_valid;
   logic [14:0] in_excp_code;
   logic [31:0] in_excp_badv;
   logic        icache_ready;
   logic [31:0] icache_inst;
   logic        is_flush;
   logic        stall_req;
   logic [2:0]  iq_count;

   fetch2_if ifc ();

   fetch2 #(.IQ_DEPTH(D), .NOP_INST(NOP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_is_flush  (in_is_flush),
      .in_pc        (in_pc),
      .in_btb_pre   (in_btb_pre),
      .in_excp_valid(in_excp_valid),
      .in_excp_code (in_excp_code),
      .in_excp_badv (in_excp_badv),
      .icache_ready (icache_ready),
      .icache_inst  (icache_inst),
      .is_flush     (is_flush),
      .stall_req    (stall_req),
      .iq_count     (iq_count),
      .iq           (ifc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] btb;
      logic        ev;
      logic [14:0] ec;
      logic [31:0] eb;
   } ent_t;

   ent_t exp_q [$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic check(string nm, logic [159:0] act,
                        logic [159:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, want);
   endtask

   function automatic logic [31:0] wordf(logic [31:0] pc);
      return {pc[15:0], pc[31:16]} ^ 32'h5a5a3c3c;
   endfunction

   // fetch1 side: one pending packet held until accepted
   logic        p_have, p_bub;
   ent_t        p_ent;
   logic [31:0] cur_pc;
   logic        cur_v;
   int          s_left;
   logic [31:0] s_pc;
   logic        s_rand;
   logic        g_icr, g_ordy, g_fl;
   logic        l_stall, l_ov, l_acc;
   logic [2:0]  l_cnt;
   int          cyc = 0;

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (!p_have && s_left > 0) begin
         p_ent     = '0;
         p_ent.pc  = s_pc;
         p_ent.btb = s_rand ? $urandom() : s_pc + 32'd4;
         p_ent.ev  = s_rand && ($urandom_range(0, 7) == 0);
         if (p_ent.ev) begin
            p_ent.ec = 15'($urandom());
            p_ent.eb = s_pc + 32'd2;
         end
         p_bub  = s_rand && ($urandom_range(0, 5) == 0);
         p_have = 1'b1;
         if (!p_bub) begin
            s_pc   = s_pc + 32'd4;
            s_left = s_left - 1;
         end
      end
      in_is_flush   = !p_have || p_bub;
      in_pc         = p_ent.pc;
      in_btb_pre    = p_ent.btb;
      in_excp_valid = p_ent.ev;
      in_excp_code  = p_ent.ec;
      in_excp_badv  = p_ent.eb;
      icache_ready  = g_icr;
      icache_inst   = cur_v ? wordf(cur_pc) : $urandom();
      ifc.out_ready = g_ordy;
      is_flush      = g_fl;
      #3;
      l_stall = stall_req;
      l_ov    = ifc.out_valid;
      l_cnt   = iq_count;
      l_acc   = !stall_req && !g_fl;
      if (g_fl) begin
         exp_q.delete();
         cur_v  = 1'b0;
         p_have = 1'b0;
      end else if (l_acc) begin
         if (p_have && !p_bub) begin
            ent_t e;
            e      = p_ent;
            e.inst = p_ent.ev ? NOP : wordf(p_ent.pc);
            exp_q.push_back(e);
            cur_pc = p_ent.pc;
            cur_v  = 1'b1;
         end else begin
            cur_v = 1'b0;
         end
         p_have = 1'b0;
      end
   endtask

   initial begin : monitor
      ent_t g, e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && ifc.out_valid && ifc.out_ready) begin
            g.pc   = ifc.out_pc;
            g.inst = ifc.out_inst;
            g.btb  = ifc.out_btb_pre;
            g.ev   = ifc.out_excp_valid;
            g.ec   = ifc.out_excp_code;
            g.eb   = ifc.out_excp_badv;
            if (exp_q.size() == 0) begin
               check("pop_unexpected", {g.pc}, 0);
            end else begin
               e = exp_q.pop_front();
               check("iq_head", g, e);
            end
         end
         if (rst_n) check("count_le_depth", iq_count <= 3'(D), 1);
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int c0, first, stalls, bad, miss;
      logic found;
      p_have = 0; p_bub = 0; p_ent = '0;
      cur_pc = 0; cur_v = 0; s_left = 0; s_pc = 0; s_rand = 0;
      g_icr = 1; g_ordy = 1; g_fl = 0;
      in_is_flush = 1; in_pc = 0; in_btb_pre = 0;
      in_excp_valid = 0; in_excp_code = 0; in_excp_badv = 0;
      icache_ready = 0; icache_inst = 0; is_flush = 0;
      ifc.out_ready = 0;
      #1;
      check("rst_out_valid", ifc.out_valid, 0);
      check("rst_stall", stall_req, 0);
      check("rst_count", iq_count, 0);
      check("rst_out_pc", ifc.out_pc, 0);
      check("rst_out_inst", ifc.out_inst, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // hits
      s_pc = 32'h1c000000; s_left = 6;
      tick();
      c0 = cyc;
      check("t1_accept", l_acc, 1);
      first = -1; stalls = 0;
      repeat (12) begin
         tick();
         if (l_stall) stalls++;
         if (l_ov && first < 0) first = cyc;
      end
      check("t1_latency", first - c0, 2);
      check("t1_no_stall", stalls, 0);
      check("t1_drained", exp_q.size(), 0);

      // miss
      s_pc = 32'h1c000000; s_left = 6;
      miss = 0; stalls = 0; bad = 0;
      repeat (16) begin
         g_icr = !(cur_v && cur_pc == 32'h1c000008 && miss < 3);
         if (!g_icr) miss++;
         tick();
         if (l_stall) stalls++;
         if (l_stall != !g_icr) bad++;
      end
      g_icr = 1;
      check("t2_stall_cycles", stalls, 3);
      check("t2_stall_only_on_miss", bad, 0);
      check("t2_drained", exp_q.size(), 0);

      // full queue
      g_ordy = 0; g_icr = 1;
      s_pc = 32'h1c000100; s_left = 5;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (l_cnt == 3'd4 && l_stall) found = 1;
      end
      check("t3_full_stall", found, 1);
      g_icr = 0; g_ordy = 1;
      tick();
      check("t3_stall_on_pop", l_stall, 1);
      check("t3_count_full", l_cnt, 4);
      g_ordy = 0;
      tick();
      check("t3_count_after_pop", l_cnt, 3);
      check("t3_buf_push", l_stall, 0);
      tick();
      check("t3_count_refill", l_cnt, 4);
      g_ordy = 1; g_icr = 1;
      repeat (8) tick();
      check("t3_drained", exp_q.size(), 0);
      check("t3_count_zero", l_cnt, 0);

      // exception
      p_ent = '0;
      p_ent.pc = 32'h1c000200; p_ent.btb = 32'h1c000204;
      p_ent.ev = 1; p_ent.ec = 15'h0008; p_ent.eb = 32'h1c000002;
      p_bub = 0; p_have = 1; s_left = 0;
      g_icr = 0; g_ordy = 1;
      tick();
      check("t4_accept", l_acc, 1);
      tick();
      check("t4_no_stall", l_stall, 0);
      tick();
      check("t4_out_valid", l_ov, 1);
      check("t4_out_inst", ifc.out_inst, NOP);
      check("t4_out_badv", ifc.out_excp_badv, 32'h1c000002);
      repeat (2) tick();
      check("t4_drained", exp_q.size(), 0);

      // flush with 3 queued and a miss in s2
      g_ordy = 0;
      s_pc = 32'h1c000300; s_left = 4;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         g_icr = !(cur_v && cur_pc == 32'h1c00030c);
         tick();
         if (l_cnt == 3'd3 && l_stall) found = 1;
      end
      check("t5_setup", found, 1);
      g_fl = 1;
      tick();
      check("t5_flush_ov", l_ov, 0);
      check("t5_flush_stall", l_stall, 0);
      g_fl = 0; g_ordy = 1; g_icr = 1;
      s_pc = 32'h1c000800; s_left = 10;
      tick();
      check("t5_count_cleared", l_cnt, 0);
      check("t5_new_pc_accept", l_acc, 1);
      repeat (30) begin
         g_icr = 1'($urandom_range(0, 1));
         tick();
      end
      g_icr = 1;
      repeat (6) tick();
      check("t5_wrap_drained", exp_q.size(), 0);

      // async reset mid-stream
      s_pc = 32'h1c000900; s_left = 20;
      repeat (5) begin
         g_ordy = 1'($urandom_range(0, 1));
         tick();
      end
      @(negedge clk);
      #4 rst_n = 1'b0;
      #1;
      check("t6_ov", ifc.out_valid, 0);
      check("t6_stall", stall_req, 0);
      check("t6_count", iq_count, 0);
      check("t6_out_pc", ifc.out_pc, 0);
      exp_q.delete();
      cur_v = 0; p_have = 0; s_left = 0;
      in_is_flush = 1; is_flush = 0; ifc.out_ready = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      g_ordy = 1; g_icr = 1;
      s_pc = 32'h1c000a00; s_left = 8;
      repeat (14) tick();
      check("t6_drained", exp_q.size(), 0);

      // randomized traffic
      s_rand = 1; s_pc = 32'h1c001000; s_left = 1000;
      repeat (300) begin
         g_icr  = ($urandom_range(0, 3) != 0);
         g_ordy = ($urandom_range(0, 2) != 0);
         g_fl   = ($urandom_range(0, 39) == 0);
         tick();
      end
      g_fl = 0; s_left = 0; g_icr = 1; g_ordy = 1;
      repeat (12) tick();
      check("rand_drained", exp_q.size(), 0);
      check("rand_count_zero", l_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
